// File: rtl/core_pkg.sv
// Shared definitions for the core control sequencer: state encoding, decoder
// instruction classes (extop), PC source selects and mcause codes.
package core_pkg;

    typedef enum logic [3:0] {
        StBoot    = 4'd0,
        StIfReq   = 4'd1,
        StIfWait  = 4'd2,
        StId      = 4'd3,
        StEx      = 4'd4,
        StMemReq  = 4'd5,
        StMemWait = 4'd6,
        StWb      = 4'd7,
        StTrap    = 4'd8,
        StHalt    = 4'd9
    } state_e;

    // Decoder instruction classes.
    localparam logic [3:0] ExtJalr   = 4'd0;
    localparam logic [3:0] ExtLoad   = 4'd1;
    localparam logic [3:0] ExtArithI = 4'd2;
    localparam logic [3:0] ExtFence  = 4'd3;
    localparam logic [3:0] ExtCsr    = 4'd4;
    localparam logic [3:0] ExtStore  = 4'd5;
    localparam logic [3:0] ExtBranch = 4'd6;
    localparam logic [3:0] ExtJal    = 4'd7;
    localparam logic [3:0] ExtLui    = 4'd8;
    localparam logic [3:0] ExtAuipc  = 4'd9;
    localparam logic [3:0] ExtRType  = 4'd10;
    localparam logic [3:0] ExtSystem = 4'd11;

    // PC source selects.
    localparam logic [1:0] PcSelSeq   = 2'd0;
    localparam logic [1:0] PcSelTgt   = 2'd1;
    localparam logic [1:0] PcSelMtvec = 2'd2;
    localparam logic [1:0] PcSelMepc  = 2'd3;

    // mcause codes.
    localparam logic [3:0] CauseFetchFault = 4'd1;
    localparam logic [3:0] CauseLoadFault  = 4'd5;
    localparam logic [3:0] CauseStoreFault = 4'd7;
    localparam logic [3:0] CauseEcall      = 4'd11;

    // Instruction classes that write a destination register.
    function automatic logic writes_rd(input logic [3:0] op);
        return op inside {ExtJalr, ExtLoad, ExtArithI, ExtCsr, ExtJal, ExtLui, ExtAuipc,
                          ExtRType};
    endfunction

endpackage

// File: rtl/core_seq_fsm_if.sv
// IFU and LSU request/response handshakes between the sequencer (master) and
// the fetch/load-store units (slave).
interface core_seq_fsm_if;
    logic ifu_req_valid;
    logic ifu_req_ready;
    logic ifu_rsp_valid;
    logic ifu_rsp_err;
    logic lsu_req_valid;
    logic lsu_req_we;
    logic lsu_req_ready;
    logic lsu_rsp_valid;
    logic lsu_rsp_err;

    modport master (
        output ifu_req_valid,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_err,
        output lsu_req_valid,
        output lsu_req_we,
        input  lsu_req_ready,
        input  lsu_rsp_valid,
        input  lsu_rsp_err
    );

    modport slave (
        input  ifu_req_valid,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_err,
        input  lsu_req_valid,
        input  lsu_req_we,
        output lsu_req_ready,
        output lsu_rsp_valid,
        output lsu_rsp_err
    );
endinterface

// File: rtl/seq_wait_timer.sv
// Wait-cycle counter for bounded IFU/LSU response waits. Clear has priority;
// the count saturates at LIMIT and holds expired high.
module seq_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CntW = (LIMIT < 255) ? 8 : $clog2(LIMIT + 1);

    logic [CntW-1:0] cnt_q;

    assign expired = (cnt_q == CntW'(LIMIT));

    // Count waiting cycles since the last clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/core_seq_fsm.sv
// Multi-cycle control sequencer: fetch, decode settle, execute, memory,
// writeback, trap and halt. Define CORE_SEQ_TIMEOUT_EN to bound IFU/LSU
// response waits to TIMEOUT cycles (expiry traps as an access fault).
module core_seq_fsm
    import core_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    core_seq_fsm_if.master     bus,
    input  logic [3:0]         extop,
    input  logic               is_ecall,
    input  logic               is_ebreak,
    input  logic               is_mret,
    input  logic               branch_taken,
    output logic               instr_we,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic               rf_we,
    output logic               csr_we,
    output logic               trap_we,
    output logic [3:0]         trap_cause,
    output logic               halted,
    output logic [3:0]         state_o
);
    // Sequencing only supports the 32-bit datapath and a non-zero wait bound.
    if (WIDTH != 32 || TIMEOUT == 0) begin : g_cfg_err
        $error("core_seq_fsm: unsupported WIDTH or TIMEOUT");
    end

    state_e     state_q, state_d;
    logic [3:0] cause_q, cause_d;
    logic       wait_expired;
    logic       is_store;

    assign is_store = (extop == ExtStore);
    assign state_o  = state_q;

`ifdef CORE_SEQ_TIMEOUT_EN
    logic wait_clr, wait_en;

    // Restart the count on every entry into a response wait.
    assign wait_clr = (state_d == StIfWait  && state_q != StIfWait) ||
                      (state_d == StMemWait && state_q != StMemWait);
    assign wait_en  = (state_q == StIfWait) || (state_q == StMemWait);

    seq_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wait_clr),
        .en      (wait_en),
        .expired (wait_expired)
    );
`else
    assign wait_expired = 1'b0;
`endif

    // State and trap-cause registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            cause_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next-state and Moore outputs; WB pc_sel/rf_we/csr_we qualified by decoder.
    always_comb begin
        state_d           = state_q;
        cause_d           = cause_q;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_we    = 1'b0;
        instr_we          = 1'b0;
        pc_we             = 1'b0;
        pc_sel            = PcSelSeq;
        rf_we             = 1'b0;
        csr_we            = 1'b0;
        trap_we           = 1'b0;
        trap_cause        = 4'd0;
        halted            = 1'b0;

        unique case (state_q)
            StBoot: state_d = StIfReq;
            StIfReq: begin
                bus.ifu_req_valid = 1'b1;
                if (bus.ifu_req_ready) state_d = StIfWait;
            end
            StIfWait: begin
                if (bus.ifu_rsp_valid) begin
                    if (bus.ifu_rsp_err) begin
                        state_d = StTrap;
                        cause_d = CauseFetchFault;
                    end else begin
                        instr_we = 1'b1;
                        state_d  = StId;
                    end
                end else if (wait_expired) begin
                    state_d = StTrap;
                    cause_d = CauseFetchFault;
                end
            end
            StId: state_d = StEx;
            StEx: begin
                if (is_ebreak) begin
                    state_d = StHalt;
                end else if (is_ecall) begin
                    state_d = StTrap;
                    cause_d = CauseEcall;
                end else if (extop == ExtLoad || is_store) begin
                    state_d = StMemReq;
                end else begin
                    state_d = StWb;
                end
            end
            StMemReq: begin
                bus.lsu_req_valid = 1'b1;
                bus.lsu_req_we    = is_store;
                if (bus.lsu_req_ready) state_d = StMemWait;
            end
            StMemWait: begin
                if ((bus.lsu_rsp_valid && bus.lsu_rsp_err) ||
                    (!bus.lsu_rsp_valid && wait_expired)) begin
                    state_d = StTrap;
                    cause_d = is_store ? CauseStoreFault : CauseLoadFault;
                end else if (bus.lsu_rsp_valid) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                pc_we  = 1'b1;
                rf_we  = !is_mret && writes_rd(extop);
                csr_we = (extop == ExtCsr);
                if (is_mret) begin
                    pc_sel = PcSelMepc;
                end else if (extop == ExtJalr || extop == ExtJal ||
                             (extop == ExtBranch && branch_taken)) begin
                    pc_sel = PcSelTgt;
                end
                state_d = StIfReq;
            end
            StTrap: begin
                trap_we    = 1'b1;
                pc_we      = 1'b1;
                pc_sel     = PcSelMtvec;
                trap_cause = cause_q;
                state_d    = StIfReq;
            end
            StHalt: halted = 1'b1;
            default: state_d = StBoot;
        endcase
    end
endmodule

// File: tb/tb_core_seq_fsm.sv
// Directed bench for core_seq_fsm: inputs change just after the falling edge,
// outputs are checked 1 ns later, well clear of the rising edge.
module tb_core_seq_fsm;
    logic       clk;
    logic       rst_n;
    logic [3:0] extop;
    logic       is_ecall, is_ebreak, is_mret, branch_taken;
    logic       instr_we, pc_we, rf_we, csr_we, trap_we, halted;
    logic [1:0] pc_sel;
    logic [3:0] trap_cause, state_o;

    int errors = 0;
    int checks = 0;

    core_seq_fsm_if bus ();

    core_seq_fsm #(
        .WIDTH   (32),
        .TIMEOUT (255)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .extop        (extop),
        .is_ecall     (is_ecall),
        .is_ebreak    (is_ebreak),
        .is_mret      (is_mret),
        .branch_taken (branch_taken),
        .instr_we     (instr_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .csr_we       (csr_we),
        .trap_we      (trap_we),
        .trap_cause   (trap_cause),
        .halted       (halted),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts in IF_REQ right after a falling edge; returns in EX (+1 ns).
    task automatic fetch(input logic [3:0] op, input logic ec, input logic eb,
                         input logic mr, input logic tk, input logic stray);
        if (stray) begin
            bus.ifu_rsp_valid = 1'b1;
            bus.ifu_req_ready = 1'b0;
            #1;
            chk("stray_ifreq_valid", bus.ifu_req_valid, 1);
            @(negedge clk);
            bus.ifu_rsp_valid = 1'b0;
        end
        bus.ifu_req_ready = 1'b1;
        #1;
        chk("ifreq_state", state_o, 1);
        chk("ifreq_valid", bus.ifu_req_valid, 1);
        @(negedge clk);
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_err   = 1'b0;
        extop = op; is_ecall = ec; is_ebreak = eb; is_mret = mr; branch_taken = tk;
        #1;
        chk("ifwait_state", state_o, 2);
        chk("ifwait_instr_we", instr_we, 1);
        @(negedge clk);
        bus.ifu_rsp_valid = 1'b0;
        #1;
        chk("id_state", state_o, 3);
        @(negedge clk);
        #1;
        chk("ex_state", state_o, 4);
        chk("ex_pc_we", pc_we, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        extop = 4'd0; is_ecall = 0; is_ebreak = 0; is_mret = 0; branch_taken = 0;
        bus.ifu_req_ready = 0; bus.ifu_rsp_valid = 0; bus.ifu_rsp_err = 0;
        bus.lsu_req_ready = 0; bus.lsu_rsp_valid = 0; bus.lsu_rsp_err = 0;

        // Reset and BOOT.
        @(negedge clk);
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_ifu_valid", bus.ifu_req_valid, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_cause", trap_cause, 0);
        chk("rst_halted", halted, 0);
        rst_n = 1'b1;
        #1;
        chk("boot_state", state_o, 0);
        chk("boot_ifu_valid", bus.ifu_req_valid, 0);

        // addi, zero-wait: IF_REQ..WB then back to IF_REQ after 5 cycles.
        @(negedge clk);
        fetch(4'd2, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("addi_wb_state", state_o, 7);
        chk("addi_rf_we", rf_we, 1);
        chk("addi_pc_we", pc_we, 1);
        chk("addi_pc_sel", pc_sel, 0);
        chk("addi_csr_we", csr_we, 0);
        @(negedge clk);
        bus.lsu_rsp_valid = 1'b1;  // stray LSU completion, must be ignored
        #1;
        chk("addi_next_ifreq", state_o, 1);
        chk("addi_next_pc_we", pc_we, 0);

        // Load with ready delayed 3 cycles, response 2 cycles later.
        fetch(4'd1, 0, 0, 0, 0, 1);
        bus.lsu_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.lsu_rsp_valid = (i == 0);  // completion before acceptance is ignored
            bus.lsu_req_ready = (i == 3);
            #1;
            chk("ld_memreq_state", state_o, 5);
            chk("ld_req_valid", bus.lsu_req_valid, 1);
            chk("ld_req_we", bus.lsu_req_we, 0);
            chk("ld_memreq_pc_we", pc_we, 0);
        end
        @(negedge clk);
        bus.lsu_req_ready = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        #1;
        chk("ld_memwait_state", state_o, 6);
        chk("ld_memwait_valid", bus.lsu_req_valid, 0);
        @(negedge clk);
        bus.lsu_rsp_valid = 1'b1;
        #1;
        chk("ld_memwait2_state", state_o, 6);
        chk("ld_memwait_pc_we", pc_we, 0);
        @(negedge clk);
        bus.lsu_rsp_valid = 1'b0;
        #1;
        chk("ld_wb_state", state_o, 7);
        chk("ld_rf_we", rf_we, 1);
        chk("ld_pc_we", pc_we, 1);

        // Branch taken then not taken.
        @(negedge clk);
        fetch(4'd6, 0, 0, 0, 1, 0);
        @(negedge clk); #1;
        chk("br_t_pc_sel", pc_sel, 1);
        chk("br_t_rf_we", rf_we, 0);
        chk("br_t_pc_we", pc_we, 1);
        @(negedge clk);
        fetch(4'd6, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("br_nt_pc_sel", pc_sel, 0);
        chk("br_nt_rf_we", rf_we, 0);

        // csr write, fence, jal.
        @(negedge clk);
        fetch(4'd4, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("csr_csr_we", csr_we, 1);
        chk("csr_rf_we", rf_we, 1);
        @(negedge clk);
        fetch(4'd3, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("fence_rf_we", rf_we, 0);
        chk("fence_pc_sel", pc_sel, 0);
        @(negedge clk);
        fetch(4'd7, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("jal_rf_we", rf_we, 1);
        chk("jal_pc_sel", pc_sel, 1);

        // ecall traps, then mret returns via mepc.
        @(negedge clk);
        fetch(4'd11, 1, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("ecall_state", state_o, 8);
        chk("ecall_cause", trap_cause, 11);
        chk("ecall_trap_we", trap_we, 1);
        chk("ecall_pc_sel", pc_sel, 2);
        chk("ecall_pc_we", pc_we, 1);
        chk("ecall_rf_we", rf_we, 0);
        @(negedge clk); #1;
        chk("ecall_next_state", state_o, 1);
        chk("ecall_next_pc_we", pc_we, 0);
        fetch(4'd11, 0, 0, 1, 0, 0);
        @(negedge clk); #1;
        chk("mret_state", state_o, 7);
        chk("mret_pc_sel", pc_sel, 3);
        chk("mret_rf_we", rf_we, 0);

        // Fetch access fault.
        @(negedge clk);
        bus.ifu_req_ready = 1'b1;
        #1;
        chk("ff_ifreq_state", state_o, 1);
        @(negedge clk);
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_err   = 1'b1;
        #1;
        chk("ff_instr_we", instr_we, 0);
        @(negedge clk);
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_err   = 1'b0;
        #1;
        chk("ff_state", state_o, 8);
        chk("ff_cause", trap_cause, 1);

        // Store access fault.
        @(negedge clk);
        fetch(4'd5, 0, 0, 0, 0, 0);
        @(negedge clk);
        bus.lsu_req_ready = 1'b1;
        #1;
        chk("st_req_we", bus.lsu_req_we, 1);
        @(negedge clk);
        bus.lsu_req_ready = 1'b0;
        bus.lsu_rsp_valid = 1'b1;
        bus.lsu_rsp_err   = 1'b1;
        #1;
        chk("st_memwait_state", state_o, 6);
        @(negedge clk);
        bus.lsu_rsp_valid = 1'b0;
        bus.lsu_rsp_err   = 1'b0;
        #1;
        chk("st_fault_state", state_o, 8);
        chk("st_fault_cause", trap_cause, 7);

        // Asynchronous reset in the middle of MEM_WAIT.
        @(negedge clk);
        fetch(4'd1, 0, 0, 0, 0, 0);
        @(negedge clk);
        bus.lsu_req_ready = 1'b1;
        #1;
        chk("ar_memreq_valid", bus.lsu_req_valid, 1);
        @(negedge clk);
        bus.lsu_req_ready = 1'b0;
        #1;
        chk("ar_memwait_state", state_o, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_async_state", state_o, 0);
        chk("ar_lsu_valid", bus.lsu_req_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.lsu_rsp_valid = 1'b1;  // late response from the aborted access
        #1;
        chk("ar_boot_state", state_o, 0);
        @(negedge clk);
        bus.lsu_rsp_valid = 1'b0;
        #1;
        chk("ar_ifreq_state", state_o, 1);

        // ebreak halts until reset.
        fetch(4'd11, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.ifu_rsp_valid = i[0];
            bus.ifu_req_ready = 1'b1;
            #1;
            chk("halt_state", state_o, 9);
            chk("halt_halted", halted, 1);
            chk("halt_strobes", {pc_we, rf_we, csr_we, trap_we, instr_we,
                                 bus.ifu_req_valid, bus.lsu_req_valid}, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
